execute_pipe: RTL and testbench

EXECUTE_PIPE -- requirements
Module: execute_pipe

---
 rtl/exec_pkg.sv | 40 ++++
 rtl/execute_pipe_if.sv | 47 ++++
 rtl/exec_alu.sv | 55 +++++
 rtl/execute_pipe.sv | 102 ++++++++++
 tb/tb_execute_pipe.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU ops, address-base selects, opcode and class codes.
package exec_pkg;

  typedef enum logic [1:0] {
    AluAdd  = 2'd0,
    AluAnd  = 2'd1,
    AluNot  = 2'd2,
    AluXnor = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    PcOff11 = 2'd0,
    PcOff9  = 2'd1,
    PcOff6  = 2'd2,
    PcZero  = 2'd3
  } pcsel1_e;

  // Field order matches E_Control = {alu_control, pcselect1, pcselect2, op2select}.
  typedef struct packed {
    alu_op_e alu_op;
    pcsel1_e pcsel1;
    logic    pcsel2;
    logic    op2sel;
  } e_ctrl_t;

  localparam logic [3:0] OpBr  = 4'b0000;
  localparam logic [3:0] OpJmp = 4'b1100;

  // IR[13:12] instruction classes.
  localparam logic [1:0] ClsCtrl  = 2'b00;
  localparam logic [1:0] ClsAlu   = 2'b01;
  localparam logic [1:0] ClsLoad  = 2'b10;
  localparam logic [1:0] ClsStore = 2'b11;

  // Branches and jumps compute their target from the current PC, i.e. npc - 1.
  function automatic logic uses_cur_pc(logic [3:0] opcode);
    return (opcode == OpBr) || (opcode == OpJmp);
  endfunction

endpackage

// File: rtl/execute_pipe_if.sv
// Handshake and datapath bundle between the decode side and the execute stage.
interface execute_pipe_if #(
    parameter int unsigned DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       IR;
    logic [DATA_W-1:0] npc;
    logic [5:0]        E_Control;
    logic [1:0]        W_Control_in;
    logic              Mem_Control_in;
    logic [DATA_W-1:0] VSR1;
    logic [DATA_W-1:0] VSR2;
    logic              bypass_alu_1;
    logic              bypass_alu_2;
    logic              bypass_mem_1;
    logic              bypass_mem_2;
    logic [DATA_W-1:0] mem_bypass_val;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] pcout;
    logic [DATA_W-1:0] M_Data;
    logic              alucarry;
    logic [1:0]        W_Control_out;
    logic              Mem_Control_out;
    logic [2:0]        NZP;
    logic [2:0]        sr1;
    logic [2:0]        sr2;
    logic [2:0]        dr;

    modport master (
        output in_valid, IR, npc, E_Control, W_Control_in, Mem_Control_in, VSR1, VSR2,
               bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, mem_bypass_val,
               out_ready,
        input  in_ready, out_valid, aluout, pcout, M_Data, alucarry, W_Control_out,
               Mem_Control_out, NZP, sr1, sr2, dr
    );

    modport slave (
        input  in_valid, IR, npc, E_Control, W_Control_in, Mem_Control_in, VSR1, VSR2,
               bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, mem_bypass_val,
               out_ready,
        output in_ready, out_valid, aluout, pcout, M_Data, alucarry, W_Control_out,
               Mem_Control_out, NZP, sr1, sr2, dr
    );
endinterface

// File: rtl/exec_alu.sv
// Combinational execute datapath: ALU ops for class-01 instructions, address adder otherwise.
module exec_alu
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [3:0]        opcode,
    input  logic [10:0]       imm,
    input  e_ctrl_t           ctrl,
    input  logic [DATA_W-1:0] npc,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] result,
    output logic              carry
);
    logic [DATA_W-1:0] off11, off9, off6, imm5;
    logic [DATA_W-1:0] in1, in2, npc_eff;
    logic [DATA_W:0]   sum;
    logic              alu_mode;

    assign off11    = {{(DATA_W-11){imm[10]}}, imm[10:0]};
    assign off9     = {{(DATA_W-9){imm[8]}}, imm[8:0]};
    assign off6     = {{(DATA_W-6){imm[5]}}, imm[5:0]};
    assign imm5     = {{(DATA_W-5){imm[4]}}, imm[4:0]};
    assign alu_mode = (opcode[1:0] == ClsAlu);

    always_comb begin
        npc_eff = uses_cur_pc(opcode) ? npc - DATA_W'(1) : npc;
        in1     = '0;
        in2     = '0;
        if (alu_mode) begin
            in1 = op_a;
            in2 = ctrl.op2sel ? op_b : imm5;
        end else begin
            unique case (ctrl.pcsel1)
                PcOff11: in1 = off11;
                PcOff9:  in1 = off9;
                PcOff6:  in1 = off6;
                PcZero:  in1 = '0;
            endcase
            in2 = ctrl.pcsel2 ? npc_eff : op_a;
        end
        sum    = {1'b0, in1} + {1'b0, in2};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
        if (alu_mode) begin
            unique case (ctrl.alu_op)
                AluAdd:  ;
                AluAnd:  begin result = in1 & in2;    carry = 1'b0; end
                AluNot:  begin result = ~in1;         carry = 1'b0; end
                AluXnor: begin result = ~(in1 ^ in2); carry = 1'b0; end
            endcase
        end
    end
endmodule

// File: rtl/execute_pipe.sv
// Single-entry execute stage with valid/ready handshake, operand forwarding and registered results.
module execute_pipe
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter bit          BYPASS_EN = 1'b1
) (
    input logic           clock,
    input logic           reset,
    execute_pipe_if.slave bus
);
    e_ctrl_t           ctrl;
    logic              in_ready, load;
    logic [DATA_W-1:0] op_a, op_b, alu_res;
    logic              alu_carry;
    logic [2:0]        sr2, dr_d, nzp_d;

    logic              valid_q, carry_q, mc_q;
    logic [DATA_W-1:0] aluout_q, mdata_q;
    logic [2:0]        dr_q, nzp_q;
    logic [1:0]        wc_q;

    assign ctrl     = e_ctrl_t'(bus.E_Control);
    assign in_ready = !valid_q || bus.out_ready;
    assign load     = bus.in_valid && in_ready;

    // Forwarding from our own result register wins over the memory-stage value.
    always_comb begin
        op_a = bus.VSR1;
        op_b = bus.VSR2;
        if (BYPASS_EN) begin
            if (bus.bypass_alu_1)      op_a = aluout_q;
            else if (bus.bypass_mem_1) op_a = bus.mem_bypass_val;
            if (bus.bypass_alu_2)      op_b = aluout_q;
            else if (bus.bypass_mem_2) op_b = bus.mem_bypass_val;
        end
    end

    always_comb begin
        sr2   = '0;
        dr_d  = '0;
        nzp_d = '0;
        unique case (bus.IR[13:12])
            ClsAlu:   begin sr2 = bus.IR[2:0]; dr_d = bus.IR[11:9]; end
            ClsLoad:  dr_d = bus.IR[11:9];
            ClsStore: sr2 = bus.IR[11:9];
            ClsCtrl:  ;
        endcase
        if (bus.IR[15:12] == OpBr)       nzp_d = bus.IR[11:9];
        else if (bus.IR[15:12] == OpJmp) nzp_d = 3'b111;
    end

    exec_alu #(.DATA_W(DATA_W)) u_alu (
        .opcode (bus.IR[15:12]),
        .imm    (bus.IR[10:0]),
        .ctrl   (ctrl),
        .npc    (bus.npc),
        .op_a   (op_a),
        .op_b   (op_b),
        .result (alu_res),
        .carry  (alu_carry)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            aluout_q <= '0;
            carry_q  <= 1'b0;
            mdata_q  <= '0;
            dr_q     <= '0;
            nzp_q    <= '0;
            wc_q     <= '0;
            mc_q     <= 1'b0;
        end else if (load) begin
            valid_q  <= 1'b1;
            aluout_q <= alu_res;
            carry_q  <= alu_carry;
            mdata_q  <= op_b;
            dr_q     <= dr_d;
            nzp_q    <= nzp_d;
            wc_q     <= bus.W_Control_in;
            mc_q     <= bus.Mem_Control_in;
        end else if (in_ready) begin
            // Bubble: drop valid and condition codes, keep the rest for observability.
            valid_q <= 1'b0;
            nzp_q   <= '0;
        end
    end

    assign bus.in_ready        = in_ready;
    assign bus.out_valid       = valid_q;
    assign bus.aluout          = aluout_q;
    assign bus.pcout           = aluout_q;
    assign bus.alucarry        = carry_q;
    assign bus.M_Data          = mdata_q;
    assign bus.dr              = dr_q;
    assign bus.NZP             = nzp_q;
    assign bus.W_Control_out   = wc_q;
    assign bus.Mem_Control_out = mc_q;
    assign bus.sr1             = bus.IR[8:6];
    assign bus.sr2             = sr2;
endmodule

// File: tb/tb_execute_pipe.sv
// Randomised scoreboard bench for execute_pipe with directed handshake, forwarding and reset cases.
module tb_execute_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    execute_pipe_if #(.DATA_W(16)) bus ();
    execute_pipe_if #(.DATA_W(32)) bus32 ();

    execute_pipe #(.DATA_W(16), .BYPASS_EN(1'b1)) dut (.clock(clk), .reset(rst), .bus(bus));
    execute_pipe #(.DATA_W(32), .BYPASS_EN(1'b1)) dut32 (.clock(clk), .reset(rst), .bus(bus32));

    typedef struct {
        bit        iv, ordy;
        bit [15:0] ir, npc, v1, v2, mbv;
        bit [5:0]  ec;
        bit [1:0]  wc;
        bit        mc, ba1, ba2, bm1, bm2;
    } stim_t;

    typedef struct {
        bit [15:0] alu, mdata;
        bit        carry;
        bit [2:0]  dr, nzp;
        bit [1:0]  wc;
        bit        mc;
    } exp_t;

    exp_t      q[$];
    exp_t      mon_e;
    int        n_cmp = 0;
    int        n_bad = 0;
    bit        mon_en = 1'b0;
    bit        m_valid = 1'b0, nx_valid = 1'b0;
    bit [15:0] m_alu = '0, nx_alu = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sx(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    endfunction

    // Reference: what the stage should compute for one accepted instruction.
    function automatic exp_t model(input stim_t s, input bit [15:0] prev);
        exp_t e;
        int a, b, in2, base, off, r;
        int op  = int'(s.ir[15:12]);
        int cls = int'(s.ir[13:12]);
        a = s.ba1 ? int'(prev) : s.bm1 ? int'(s.mbv) : int'(s.v1);
        b = s.ba2 ? int'(prev) : s.bm2 ? int'(s.mbv) : int'(s.v2);
        e.carry = 1'b0;
        r = 0;
        if (cls == 1) begin
            in2 = s.ec[0] ? b : (sx(int'(s.ir[4:0]), 5) & 'hFFFF);
            case (s.ec[5:4])
                2'd0: begin r = a + in2; e.carry = (r > 65535); end
                2'd1: r = a & in2;
                2'd2: r = ~a;
                default: r = ~(a ^ in2);
            endcase
        end else begin
            case (s.ec[3:2])
                2'd0: off = sx(int'(s.ir[10:0]), 11);
                2'd1: off = sx(int'(s.ir[8:0]), 9);
                2'd2: off = sx(int'(s.ir[5:0]), 6);
                default: off = 0;
            endcase
            if (s.ec[1]) base = (op == 0 || op == 12) ? int'(s.npc) - 1 : int'(s.npc);
            else base = a;
            r = (base & 'hFFFF) + (off & 'hFFFF);
            e.carry = (r > 65535);
        end
        e.alu   = r[15:0];
        e.mdata = b[15:0];
        e.dr    = (cls == 1 || cls == 2) ? s.ir[11:9] : 3'd0;
        e.nzp   = (op == 0) ? s.ir[11:9] : (op == 12) ? 3'd7 : 3'd0;
        e.wc    = s.wc;
        e.mc    = s.mc;
        return e;
    endfunction

    function automatic stim_t zero_stim();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.iv = ($urandom_range(0, 3) != 0);   s.ordy = ($urandom_range(0, 3) != 0);
        s.ir = 16'($urandom);  s.npc = 16'($urandom);
        s.v1 = 16'($urandom);  s.v2 = 16'($urandom);  s.mbv = 16'($urandom);
        s.ec = 6'($urandom);   s.wc = 2'($urandom);   s.mc = 1'($urandom);
        s.ba1 = 1'($urandom);  s.ba2 = 1'($urandom);
        s.bm1 = 1'($urandom);  s.bm2 = 1'($urandom);
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.in_valid = s.iv;  bus.out_ready = s.ordy;
        bus.IR = s.ir;  bus.npc = s.npc;  bus.E_Control = s.ec;
        bus.W_Control_in = s.wc;  bus.Mem_Control_in = s.mc;
        bus.VSR1 = s.v1;  bus.VSR2 = s.v2;  bus.mem_bypass_val = s.mbv;
        bus.bypass_alu_1 = s.ba1;  bus.bypass_alu_2 = s.ba2;
        bus.bypass_mem_1 = s.bm1;  bus.bypass_mem_2 = s.bm2;
    endtask

    // Advance one edge, then present new stimulus and record what it should produce.
    task automatic step(input stim_t s);
        @(posedge clk);
        m_valid = nx_valid;
        m_alu   = nx_alu;
        #1;
        drive(s);
        if (s.iv && (!m_valid || s.ordy)) begin
            exp_t e;
            e = model(s, m_alu);
            q.push_back(e);
            nx_valid = 1'b1;
            nx_alu   = e.alu;
        end else if (!m_valid || s.ordy) begin
            nx_valid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("in_ready", bus.in_ready, !m_valid || bus.out_ready);
            chk("out_valid", bus.out_valid, m_valid);
            chk("sr1", bus.sr1, bus.IR[8:6]);
            chk("sr2", bus.sr2, (bus.IR[13:12] == 2'b01) ? bus.IR[2:0] :
                                (bus.IR[13:12] == 2'b11) ? bus.IR[11:9] : 3'd0);
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("queue_underflow", 1, 0);
                end else begin
                    mon_e = q[0];
                    chk("aluout", bus.aluout, mon_e.alu);
                    chk("pcout", bus.pcout, mon_e.alu);
                    chk("alucarry", bus.alucarry, mon_e.carry);
                    chk("M_Data", bus.M_Data, mon_e.mdata);
                    chk("dr", bus.dr, mon_e.dr);
                    chk("NZP", bus.NZP, mon_e.nzp);
                    chk("W_Control_out", bus.W_Control_out, mon_e.wc);
                    chk("Mem_Control_out", bus.Mem_Control_out, mon_e.mc);
                    if (bus.out_ready) void'(q.pop_front());
                end
            end else begin
                chk("NZP_idle", bus.NZP, 3'd0);
            end
        end
    end

    initial begin
        stim_t s, idle, hold, drain, st;
        idle  = zero_stim();
        hold  = idle;
        drain = idle;  drain.ordy = 1'b1;
        drive(idle);
        bus32.in_valid = 1'b0;  bus32.out_ready = 1'b1;  bus32.IR = '0;  bus32.npc = '0;
        bus32.E_Control = '0;  bus32.W_Control_in = '0;  bus32.Mem_Control_in = 1'b0;
        bus32.VSR1 = '0;  bus32.VSR2 = '0;  bus32.mem_bypass_val = '0;
        bus32.bypass_alu_1 = 1'b0;  bus32.bypass_alu_2 = 1'b0;
        bus32.bypass_mem_1 = 1'b0;  bus32.bypass_mem_2 = 1'b0;
        #4;
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_aluout", bus.aluout, 16'h0);
        #8;
        rst = 1'b0;
        mon_en = 1'b1;
        chk("reset_in_ready", bus.in_ready, 1'b1);

        // 32-bit wrap: 0xFFFFFFFF + 1 through the register operand.
        bus32.in_valid = 1'b1;  bus32.IR = 16'h1283;  bus32.E_Control = 6'b000001;
        bus32.VSR1 = 32'hFFFF_FFFF;  bus32.VSR2 = 32'h1;

        // Back-to-back ADD R1,R1,#1 forwarding our own result over a stale VSR1 of 0.
        s = idle;  s.iv = 1'b1;  s.ordy = 1'b1;  s.ir = 16'h1261;  s.ba1 = 1'b1;
        step(s);
        chk("w32_aluout", bus32.aluout, 32'h0);
        chk("w32_carry", bus32.alucarry, 1'b1);
        chk("w32_valid", bus32.out_valid, 1'b1);
        bus32.IR = 16'h12BF;  bus32.E_Control = 6'b000000;  bus32.VSR1 = 32'h0;
        step(s);
        chk("byp_1", bus.aluout, 16'h1);
        chk("w32_imm_neg", bus32.aluout, 32'hFFFF_FFFF);
        chk("w32_imm_carry", bus32.alucarry, 1'b0);
        bus32.in_valid = 1'b0;
        step(s);
        chk("byp_2", bus.aluout, 16'h2);
        step(drain);
        chk("byp_3", bus.aluout, 16'h3);

        // ADD R1,R2,#5 with VSR1 = 0x10.
        s = idle;  s.iv = 1'b1;  s.ordy = 1'b1;  s.ir = 16'h12A5;  s.v1 = 16'h0010;
        step(s);
        step(hold);
        chk("add_imm_aluout", bus.aluout, 16'h0015);
        chk("add_imm_dr", bus.dr, 3'd1);
        chk("add_imm_nzp", bus.NZP, 3'd0);
        chk("add_imm_valid", bus.out_valid, 1'b1);

        // BR nzp with PC-relative target.
        s = idle;  s.iv = 1'b1;  s.ordy = 1'b1;  s.ir = 16'h0E03;  s.npc = 16'h3001;
        s.ec = 6'b000110;
        step(s);
        step(hold);
        chk("br_pcout", bus.pcout, 16'h3003);
        chk("br_nzp", bus.NZP, 3'd7);

        // Three stalled cycles with fresh input waiting.
        for (int i = 0; i < 3; i++) begin
            st = rnd();  st.iv = 1'b1;  st.ordy = 1'b0;
            step(st);
            chk("stall_in_ready", bus.in_ready, 1'b0);
            chk("stall_aluout", bus.aluout, 16'h3003);
        end
        step(drain);
        step(drain);
        chk("bubble_valid", bus.out_valid, 1'b0);
        chk("bubble_nzp", bus.NZP, 3'd0);

        // Asynchronous reset in the middle of a stall throws the held result away.
        s = idle;  s.iv = 1'b1;  s.ordy = 1'b1;  s.ir = 16'h12A5;  s.v1 = 16'h0010;
        step(s);
        step(hold);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_valid", bus.out_valid, 1'b0);
        chk("midreset_aluout", bus.aluout, 16'h0);
        chk("midreset_dr", bus.dr, 3'd0);
        q.delete();
        m_valid = 1'b0;  nx_valid = 1'b0;  m_alu = '0;  nx_alu = '0;
        bus.in_valid = 1'b0;
        #4;
        rst = 1'b0;
        chk("midreset_in_ready", bus.in_ready, 1'b1);

        repeat (400) step(rnd());
        step(drain);
        step(drain);
        chk("queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
